// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, data-enable and lock status from active-high hsync/vsync.
// Latency: coordinates realign on the clock that samples a sync rising edge; locked/sync_err are registered.
// Backpressure: none; free-running on the pixel clock, and the inputs are sampled every cycle.
module vga_sync_decoder #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int H_TOTAL      = 800,
   parameter int V_TOTAL      = 525,
   parameter int H_SYNC_START = 656,
   parameter int V_SYNC_START = 490,
   parameter int LOCK_LINES   = 2
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       hsync_in,
   input  logic       vsync_in,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       de,
   output logic       frame_start,
   output logic       locked,
   output logic       sync_err
);

   localparam logic [9:0]  X_LAST      = 10'(H_TOTAL - 1);
   localparam logic [9:0]  X_LOAD      = 10'(H_SYNC_START + 1);
   localparam logic [9:0]  Y_LAST      = 10'(V_TOTAL - 1);
   localparam logic [9:0]  Y_LOAD      = 10'(V_SYNC_START);
   localparam logic [9:0]  X_ACT       = 10'(H_ACTIVE);
   localparam logic [9:0]  Y_ACT       = 10'(V_ACTIVE);
   localparam logic [10:0] H_PERIOD_M1 = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_SAT       = 11'(2 * H_TOTAL);
   localparam logic [10:0] V_PERIOD    = 11'(V_TOTAL);
   localparam logic [10:0] V_SAT       = 11'(2 * V_TOTAL);
   localparam logic [3:0]  LOCK_N      = 4'(LOCK_LINES);

   logic        hs_prev_q, hs_prev_d;
   logic        vs_prev_q, vs_prev_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic [3:0]  good_q, good_d;
   logic        h_ok_q, h_ok_d;
   logic        v_ok_q, v_ok_d;
   logic        h_run_q, h_run_d;    // first hsync edge seen: line measurement armed
   logic        v_run_q, v_run_d;    // first vsync edge seen: frame measurement armed
   logic        locked_q, locked_d;
   logic        sync_err_q, sync_err_d;
   logic        hs_edge, vs_edge;
   logic        h_err, v_err;

   assign hs_edge = hsync_in & ~hs_prev_q;
   assign vs_edge = vsync_in & ~vs_prev_q;

   // Next-state: coordinate counters, line/frame period checks and error collection.
   always_comb begin
      hs_prev_d  = hsync_in;
      vs_prev_d  = vsync_in;
      x_d        = x_q;
      y_d        = y_q;
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      good_d     = good_q;
      h_ok_d     = h_ok_q;
      v_ok_d     = v_ok_q;
      h_run_d    = h_run_q;
      v_run_d    = v_run_q;
      h_err      = 1'b0;
      v_err      = 1'b0;

      // x realigns on hsync; y only advances when x wraps naturally, vsync load wins
      if (hs_edge) begin
         x_d = X_LOAD;
      end else if (x_q == X_LAST) begin
         x_d = '0;
      end else begin
         x_d = x_q + 10'd1;
      end

      if (vs_edge) begin
         y_d = Y_LOAD;
      end else if (!hs_edge && (x_q == X_LAST)) begin
         y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end

      // Line period: h_cnt+1 clocks between hsync edges; saturation flags a dead hsync once
      if (hs_edge) begin
         h_run_d = 1'b1;
         h_cnt_d = '0;
         if (h_run_q) begin
            if (h_cnt_q == H_PERIOD_M1) begin
               if (good_q < LOCK_N) begin
                  good_d = good_q + 4'd1;
               end
               if (good_d == LOCK_N) begin
                  h_ok_d = 1'b1;
               end
            end else begin
               good_d = '0;
               h_ok_d = 1'b0;
               h_err  = 1'b1;
            end
         end
      end else if (h_run_q && (h_cnt_q != H_SAT)) begin
         h_cnt_d = h_cnt_q + 11'd1;
         if (h_cnt_d == H_SAT) begin
            good_d = '0;
            h_ok_d = 1'b0;
            h_err  = 1'b1;
         end
      end

      // Frame period in lines; an hsync edge coincident with vsync opens the new frame
      if (vs_edge) begin
         v_run_d = 1'b1;
         v_cnt_d = hs_edge ? 11'd1 : 11'd0;
         if (v_run_q) begin
            v_ok_d = (v_cnt_q == V_PERIOD);
            v_err  = (v_cnt_q != V_PERIOD);
         end
      end else if (hs_edge && v_run_q && (v_cnt_q != V_SAT)) begin
         v_cnt_d = v_cnt_q + 11'd1;
         if (v_cnt_d == V_SAT) begin
            v_ok_d = 1'b0;
            v_err  = 1'b1;
         end
      end

      locked_d   = h_ok_d & v_ok_d;
      sync_err_d = h_err | v_err;
   end

   // State register; sync history resets high so a sync already asserted is not an edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hs_prev_q  <= 1'b1;
         vs_prev_q  <= 1'b1;
         x_q        <= '0;
         y_q        <= '0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         good_q     <= '0;
         h_ok_q     <= 1'b0;
         v_ok_q     <= 1'b0;
         h_run_q    <= 1'b0;
         v_run_q    <= 1'b0;
         locked_q   <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         hs_prev_q  <= hs_prev_d;
         vs_prev_q  <= vs_prev_d;
         x_q        <= x_d;
         y_q        <= y_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         good_q     <= good_d;
         h_ok_q     <= h_ok_d;
         v_ok_q     <= v_ok_d;
         h_run_q    <= h_run_d;
         v_run_q    <= v_run_d;
         locked_q   <= locked_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign x_pos       = x_q;
   assign y_pos       = y_q;
   assign locked      = locked_q;
   assign sync_err    = sync_err_q;
   assign de          = locked_q & (x_q < X_ACT) & (y_q < Y_ACT);
   assign frame_start = locked_q & (x_q == 10'd0) & (y_q == 10'd0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench: a reduced 20x10 timing (frame = 200 clocks) drives the main instance;
// a default-parameter instance shares the sync inputs for the power-up edge behaviour.
module tb_vga_sync_decoder;

   localparam int HA  = 8;
   localparam int VA  = 6;
   localparam int HT  = 20;
   localparam int VT  = 10;
   localparam int HSS = 12;
   localparam int VSS = 7;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       hs, vs;
   logic [9:0] x_pos, y_pos, def_x, def_y;
   logic       de, frame_start, locked, sync_err;
   logic       def_de, def_fs, def_lock, def_err;

   int checks = 0;
   int errors = 0;
   int gx, gy, px, py;
   bit kill, short_req;
   int serr_cnt;
   int n, s0, xm, ym, dm, lm, dec, fsc, fs_t0, fs_t1, et;
   logic de_exp;

   always #20 clk = ~clk;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
      .H_SYNC_START(HSS), .V_SYNC_START(VSS), .LOCK_LINES(2)
   ) dut (
      .clk(clk), .n_rst(n_rst), .hsync_in(hs), .vsync_in(vs),
      .x_pos(x_pos), .y_pos(y_pos), .de(de), .frame_start(frame_start),
      .locked(locked), .sync_err(sync_err)
   );

   vga_sync_decoder dut_def (
      .clk(clk), .n_rst(n_rst), .hsync_in(hs), .vsync_in(vs),
      .x_pos(def_x), .y_pos(def_y), .de(def_de), .frame_start(def_fs),
      .locked(def_lock), .sync_err(def_err)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One pixel clock: generator drives registered syncs for its current position, then advances.
   // (px,py) is the position the decoder should report after this edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (sync_err === 1'b1) serr_cnt++;
      px = gx;
      py = gy;
      hs = !kill && (gx >= HSS) && (gx < HSS + 3);
      vs = (gy >= VSS) && (gy < VSS + 2);
      if ((short_req && gy == 2 && gx == HT - 2) || gx == HT - 1) begin
         if (gx != HT - 1) short_req = 0;
         gx = 0;
         gy = (gy == VT - 1) ? 0 : gy + 1;
      end else begin
         gx = gx + 1;
      end
   endtask

   initial begin
      n_rst = 1'b0; hs = 1'b1; vs = 1'b0;
      gx = 13; gy = 0; px = 0; py = 0;
      kill = 0; short_req = 0; serr_cnt = 0;
      #50;
      chk("reset_x", x_pos, 0);
      chk("reset_y", y_pos, 0);
      chk("reset_de", de, 0);
      chk("reset_frame_start", frame_start, 0);
      chk("reset_locked", locked, 0);
      chk("reset_sync_err", sync_err, 0);

      // Release with hsync already high: no edge, counters free-run from 0
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) tick();
      chk("held_high_x", x_pos, 3);
      chk("held_high_def_x", def_x, 3);
      repeat (17) tick();
      chk("free_run_wrap_x", x_pos, 0);
      tick();
      chk("first_edge_x", x_pos, HSS + 1);
      chk("first_edge_def_x", def_x, 657);
      chk("first_edge_def_no_err", def_err, 0);

      // Lock: two good lines and one checked frame; completes on the second vsync edge
      n = 0;
      while (locked !== 1'b1 && n < 400) begin tick(); n++; end
      chk("lock_reached", locked, 1);
      chk("lock_x", x_pos, 1);
      chk("lock_y", y_pos, VSS);
      chk("startup_no_sync_err", serr_cnt, 0);

      // Two locked frames: coordinates track generator, de/frame_start counts
      xm = 0; ym = 0; dm = 0; lm = 0; dec = 0; fsc = 0; fs_t0 = -1; fs_t1 = -1; s0 = serr_cnt;
      for (int i = 0; i < 2 * HT * VT; i++) begin
         tick();
         de_exp = (px < HA) && (py < VA);
         if (x_pos !== 10'(px)) xm++;
         if (y_pos !== 10'(py)) ym++;
         if (de !== de_exp) dm++;
         if (locked !== 1'b1) lm++;
         if (de === 1'b1) dec++;
         if (frame_start === 1'b1) begin
            fsc++;
            if (fs_t0 < 0) fs_t0 = i;
            else if (fs_t1 < 0) fs_t1 = i;
         end
      end
      chk("align_x_mismatches", xm, 0);
      chk("align_y_mismatches", ym, 0);
      chk("align_de_mismatches", dm, 0);
      chk("align_lock_drops", lm, 0);
      chk("de_count_2_frames", dec, 2 * HA * VA);
      chk("frame_start_count", fsc, 2);
      chk("frame_start_spacing", fs_t1 - fs_t0, HT * VT);
      chk("align_no_sync_err", serr_cnt - s0, 0);

      // One 19-clock line: error on that edge, relock exactly two good lines later
      short_req = 1;
      n = 0;
      while (sync_err !== 1'b1 && n < 250) begin tick(); n++; end
      chk("short_line_err", sync_err, 1);
      chk("short_line_unlock", locked, 0);
      s0 = serr_cnt; lm = 0;
      for (int i = 0; i < 2 * HT - 1; i++) begin
         tick();
         if (locked !== 1'b0) lm++;
      end
      chk("short_line_hold_unlocked", lm, 0);
      tick();
      chk("short_line_relock", locked, 1);
      chk("short_line_no_extra_err", serr_cnt - s0, 0);

      xm = 0; ym = 0; s0 = serr_cnt;
      for (int i = 0; i < HT * VT; i++) begin
         tick();
         if (x_pos !== 10'(px)) xm++;
         if (y_pos !== 10'(py)) ym++;
      end
      chk("realign_x_mismatches", xm, 0);
      chk("realign_y_mismatches", ym, 0);
      chk("realign_no_sync_err", serr_cnt - s0, 0);

      // Asynchronous reset mid-frame while locked
      n = 0;
      while (!(x_pos === 10'd5 && y_pos === 10'd3) && n < 250) begin tick(); n++; end
      chk("pre_reset_de", de, 1);
      chk("pre_reset_locked", locked, 1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("async_reset_x", x_pos, 0);
      chk("async_reset_y", y_pos, 0);
      chk("async_reset_de", de, 0);
      chk("async_reset_locked", locked, 0);
      repeat (2) tick();
      @(negedge clk);
      n_rst = 1'b1;
      s0 = serr_cnt;
      n = 0;
      while (locked !== 1'b1 && n < 500) begin tick(); n++; end
      chk("relock_after_reset", locked, 1);
      chk("relock_y", y_pos, VSS);
      chk("relock_no_sync_err", serr_cnt - s0, 0);

      // hsync held low: a single timeout error at 2*H_TOTAL clocks after the last edge
      n = 0;
      while (!(x_pos === 10'(HSS + 1) && y_pos === 10'd0) && n < 250) begin tick(); n++; end
      chk("kill_start_found", x_pos, HSS + 1);
      kill = 1; s0 = serr_cnt; et = -1;
      for (int k = 1; k <= 55; k++) begin
         tick();
         if (sync_err === 1'b1 && et < 0) et = k;
      end
      chk("timeout_single_err", serr_cnt - s0, 1);
      chk("timeout_err_time", et, 2 * HT);
      chk("timeout_unlock", locked, 0);
      kill = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
